spi_master_mc: RTL

- Parametrised successor to the team's single-mode SPI transfer block; single-clock SPI master.
- Adds all four CPOL/CPHA modes, a programmable SCLK divider, a one-hot multi-channel chip-select, and variable transfer length up to DATA_WIDTH.
- Sits between the system-side register interface (start/data/size) and the off-chip SPI pins; one transfer in flight at a time.

---
 rtl/spi_master_mc_if.sv | 36 +++
 rtl/spi_master_mc.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spi_master_mc_if.sv
// System-side request/response and SPI pin bundle for spi_master_mc; the master modport is the
// block's view and the slave modport is the view of whatever drives requests and models the pins.
interface spi_master_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
);
  localparam int CS_W = $clog2(NUM_CS);

  logic                  t_start;
  logic                  t_ready;
  logic [CNT_WIDTH-1:0]  t_size;
  logic [DATA_WIDTH-1:0] d_in;
  logic [CS_W-1:0]       cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic [DIV_WIDTH-1:0]  clk_div;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  d_valid;
  logic                  t_err;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_CS-1:0]     cs_n;

  modport master (
    input  t_start, t_size, d_in, cs_sel, cpol, cpha, clk_div, miso,
    output t_ready, d_out, d_valid, t_err, sclk, mosi, cs_n
  );

  modport slave (
    output t_start, t_size, d_in, cs_sel, cpol, cpha, clk_div, miso,
    input  t_ready, d_out, d_valid, t_err, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_mc.sv
// SPI master with CPOL/CPHA modes, SCLK divider, one-hot CS and 1..DATA_WIDTH bit transfers.
// d_valid (2n+2)*(clk_div+1) cycles after accept; new requests are taken only while t_ready is high.
module spi_master_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic            master_clk,
  input  logic            rst,
  spi_master_mc_if.master bus
);
  localparam int CS_W  = $clog2(NUM_CS);
  localparam int TOG_W = CNT_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, SETUP, TRANSACT, HOLD, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, hp_q, hp_d;
  logic [TOG_W-1:0]      tog_q, tog_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CS_W-1:0]       cs_q, cs_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d, t_err_q, t_err_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, d_out_q, d_out_d;

  logic                  ready, half_done, toggle, reject;
  logic [CNT_WIDTH-1:0]  n_eff, shamt;
  logic [DATA_WIDTH-1:0] tx_aligned;

  assign ready     = (state_q == IDLE) || (state_q == DONE);
  assign half_done = (div_q == hp_q);
  assign reject    = (bus.t_size == '0) || ({1'b0, bus.cs_sel} >= (CS_W + 1)'(NUM_CS));
  assign n_eff     = (bus.t_size > CNT_WIDTH'(DATA_WIDTH)) ? CNT_WIDTH'(DATA_WIDTH) : bus.t_size;
  // Left-align the field so the next bit to send is always the MSB of tx_q.
  assign shamt      = CNT_WIDTH'(DATA_WIDTH) - n_eff;
  assign tx_aligned = bus.d_in << shamt;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hp_d    = hp_q;
    tog_d   = tog_q;
    n_d     = n_q;
    cs_d    = cs_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    d_out_d = d_out_q;
    t_err_d = 1'b0;
    toggle  = 1'b0;
    if (!ready) div_d = half_done ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        mosi_d  = 1'b0;
        if (bus.t_start && reject) begin
          t_err_d = 1'b1;
        end else if (bus.t_start) begin
          state_d = SETUP;
          div_d   = '0;
          tog_d   = '0;
          hp_d    = bus.clk_div;
          n_d     = n_eff;
          cs_d    = bus.cs_sel;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          sclk_d  = bus.cpol;
          rx_d    = '0;
          // CPHA=0 must present the first bit before the first (sampling) leading edge.
          if (bus.cpha) begin
            mosi_d = 1'b0;
            tx_d   = tx_aligned;
          end else begin
            mosi_d = tx_aligned[DATA_WIDTH-1];
            tx_d   = tx_aligned << 1;
          end
        end
      end
      SETUP: if (half_done) begin
        state_d = TRANSACT;
        toggle  = 1'b1;
      end
      TRANSACT: if (half_done) begin
        if (tog_q == {n_q, 1'b0}) begin
          state_d = HOLD;
          mosi_d  = 1'b0;
        end else begin
          toggle = 1'b1;
        end
      end
      HOLD: if (half_done) begin
        state_d = DONE;
        d_out_d = rx_q;
      end
      default: state_d = IDLE;
    endcase
    // Leading edge leaves cpol; sample on it for CPHA=0, shift out on it for CPHA=1.
    if (toggle) begin
      sclk_d = ~sclk_q;
      tog_d  = tog_q + 1'b1;
      if ((sclk_q == cpol_q) ^ cpha_q) begin
        rx_d = {rx_q[DATA_WIDTH-2:0], bus.miso};
      end else begin
        mosi_d = tx_q[DATA_WIDTH-1];
        tx_d   = tx_q << 1;
      end
    end
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      tog_q   <= '0;
      n_q     <= '0;
      cs_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      d_out_q <= '0;
      t_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      tog_q   <= tog_d;
      n_q     <= n_d;
      cs_q    <= cs_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      d_out_q <= d_out_d;
      t_err_q <= t_err_d;
    end
  end

  assign bus.t_ready = ready;
  assign bus.d_out   = d_out_q;
  assign bus.d_valid = (state_q == DONE);
  assign bus.t_err   = t_err_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = (state_q inside {SETUP, TRANSACT, HOLD}) ? ~(NUM_CS'(1) << cs_q) : '1;
endmodule
